// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor around a one-bit full-subtractor cell; result valid WIDTH cycles after accept.
// Accepts only in IDLE (ready_out), holds the result in DONE until ack_in; start/ack outside those states are ignored.

module fsub_cell (
  input  logic a_in,
  input  logic b_in,
  input  logic c_in,
  output logic d_out,
  output logic b_out
);
  assign d_out = a_in ^ b_in ^ c_in;
  assign b_out = (~a_in & b_in) | (~a_in & c_in) | (b_in & c_in);
endmodule

module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             borrow_in,
  output logic             ready_out,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             valid_out,
  input  logic             ack_in
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             cell_d, cell_bo;

  fsub_cell u_cell (
    .a_in  (a_q[0]),
    .b_in  (b_q[0]),
    .c_in  (brw_q),
    .d_out (cell_d),
    .b_out (cell_bo)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    brw_d   = brw_q;
    case (state_q)
      S_IDLE: begin
        if (start_in) begin
          state_d = S_RUN;
          a_d     = a_in;
          b_d     = b_in;
          brw_d   = borrow_in;
          cnt_d   = '0;
          res_d   = '0;
        end
      end
      S_RUN: begin
        // LSB-first: each cell output enters at the MSB so bit 0 lands at position 0 after WIDTH shifts
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {cell_d, res_q[WIDTH-1:1]};
        brw_d = cell_bo;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (ack_in) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      brw_q   <= brw_d;
    end
  end

  assign ready_out  = (state_q == S_IDLE);
  assign valid_out  = (state_q == S_DONE);
  assign diff_out   = res_q;
  assign borrow_out = brw_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed and random checks of serial_sub at WIDTH=8 and WIDTH=32.
module tb_serial_sub;
  logic clk = 1'b0;
  logic rst_n;

  logic        start8, bin8, ack8, ready8, valid8, bo8;
  logic [7:0]  a8, b8, diff8;
  logic        start32, bin32, ack32, ready32, valid32, bo32;
  logic [31:0] a32, b32, diff32;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8)) u_dut8 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start8), .a_in(a8), .b_in(b8),
    .borrow_in(bin8), .ready_out(ready8), .diff_out(diff8), .borrow_out(bo8),
    .valid_out(valid8), .ack_in(ack8)
  );

  serial_sub #(.WIDTH(32)) u_dut32 (
    .clk_in(clk), .rst_n_in(rst_n), .start_in(start32), .a_in(a32), .b_in(b32),
    .borrow_in(bin32), .ready_out(ready32), .diff_out(diff32), .borrow_out(bo32),
    .valid_out(valid32), .ack_in(ack32)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the ack edge.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bin,
                     input logic [7:0] exp_d, input logic exp_bo, input int hold,
                     input logic poke_start, input logic poke_ack);
    int lat;
    check({tag, " ready_before"}, {31'd0, ready8}, 32'd1);
    start8 = 1'b1; a8 = a; b8 = b; bin8 = bin;
    @(negedge clk);
    a8 = ~a; b8 = b + 8'd1; bin8 = ~bin;
    check({tag, " ready_fall"}, {31'd0, ready8}, 32'd0);
    lat = 0;
    while (!valid8 && lat < 40) begin
      start8 = poke_start && (lat == 2);
      ack8   = poke_ack && (lat == 4);
      @(negedge clk);
      lat++;
    end
    start8 = 1'b0; ack8 = 1'b0;
    check({tag, " latency"}, lat, 32'd8);
    check({tag, " diff"}, {24'd0, diff8}, {24'd0, exp_d});
    check({tag, " borrow"}, {31'd0, bo8}, {31'd0, exp_bo});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold_valid"}, {31'd0, valid8}, 32'd1);
      check({tag, " hold_diff"}, {24'd0, diff8}, {24'd0, exp_d});
      check({tag, " hold_borrow"}, {31'd0, bo8}, {31'd0, exp_bo});
    end
    ack8 = 1'b1;
    @(negedge clk);
    ack8 = 1'b0;
    check({tag, " valid_drop"}, {31'd0, valid8}, 32'd0);
    check({tag, " ready_back"}, {31'd0, ready8}, 32'd1);
  endtask

  task automatic op32(input logic [31:0] a, input logic [31:0] b, input logic bin, input int hold);
    int lat;
    logic [32:0] ref_v;
    ref_v = {1'b0, a} - {1'b0, b} - {32'd0, bin};
    start32 = 1'b1; a32 = a; b32 = b; bin32 = bin;
    @(negedge clk);
    start32 = 1'b0; a32 = $urandom; b32 = $urandom; bin32 = 1'($urandom);
    lat = 0;
    while (!valid32 && lat < 80) begin
      @(negedge clk);
      lat++;
    end
    check("w32 latency", lat, 32'd32);
    check("w32 diff", diff32, ref_v[31:0]);
    check("w32 borrow", {31'd0, bo32}, {31'd0, ref_v[32]});
    repeat (hold) @(negedge clk);
    ack32 = 1'b1;
    @(negedge clk);
    ack32 = 1'b0;
    check("w32 ready_back", {31'd0, ready32}, 32'd1);
  endtask

  initial begin
    logic [7:0]  ra, rb;
    logic        rbin;
    logic [8:0]  ref8;
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0; ack8 = 1'b0;
    start32 = 1'b0; a32 = '0; b32 = '0; bin32 = 1'b0; ack32 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst ready", {31'd0, ready8}, 32'd1);
    check("rst valid", {31'd0, valid8}, 32'd0);
    check("rst diff", {24'd0, diff8}, 32'd0);
    check("rst borrow", {31'd0, bo8}, 32'd0);
    rst_n = 1'b1;

    op8("5a-23", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 5, 1'b1, 1'b0);
    op8("00-01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 0, 1'b0, 1'b1);
    op8("10-10-1", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1, 1'b0, 1'b0);
    op8("80-7f-1", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 0, 1'b0, 1'b0);

    // Abort a run with reset after 4 RUN cycles.
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; bin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #2;
    check("midrst ready", {31'd0, ready8}, 32'd1);
    check("midrst valid", {31'd0, valid8}, 32'd0);
    check("midrst diff", {24'd0, diff8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op8("03-05", 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 0, 1'b0, 1'b0);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rbin = 1'($urandom);
      ref8 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
      op8("rand8", ra, rb, rbin, ref8[7:0], ref8[8], $urandom_range(0, 3), 1'b0, 1'b0);
    end

    op32(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    op32(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1);
    for (int i = 0; i < 1000; i++) begin
      op32($urandom, $urandom, 1'($urandom), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
